// File: rtl/alu_pkg.sv
// Shared op/state encodings for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRA  = 4'd1,
        ALU_SRL  = 4'd2,
        ALU_MULU = 4'd3,
        ALU_DIVU = 4'd4,
        ALU_ADD  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_NOR  = 4'd10,
        ALU_SLT  = 4'd11,
        ALU_SLTU = 4'd12,
        ALU_MULS = 4'd13,
        ALU_DIVS = 4'd14,
        ALU_RSV  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic is_long_op(input logic [3:0] sel);
        return (sel == ALU_MULU) || (sel == ALU_DIVU) ||
               (sel == ALU_MULS) || (sel == ALU_DIVS);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mul,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);

    state_e           state, state_nx;
    logic [WIDTH-1:0] hi, lo, dv;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic [CW-1:0]    cnt;
    logic             neg_lo, neg_hi, mul_op;

    logic [WIDTH-1:0]   ax, ay;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign ax = (is_signed && x[WIDTH-1]) ? -x : x;
    assign ay = (is_signed && y[WIDTH-1]) ? -y : y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = is_mul ? S_MUL : S_DIV;
            S_MUL,
            S_DIV:   if (cnt == CW'(WIDTH-1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    assign trial = {hi, lo[WIDTH-1]} - {1'b0, dv};

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        if (state == S_MUL) begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            hi_nx = trial[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_nx = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Multiply: lo holds multiplier, dv multiplicand. Divide: lo dividend, dv divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            dv     <= '0;
            cnt    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            mul_op <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                hi     <= '0;
                lo     <= is_mul ? ay : ax;
                dv     <= is_mul ? ax : ay;
                cnt    <= '0;
                neg_lo <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                neg_hi <= is_signed & ~is_mul & x[WIDTH-1];
                mul_op <= is_mul;
            end
        end else if (state == S_MUL || state == S_DIV) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
        end
    end

    assign prod = neg_lo ? -{hi, lo} : {hi, lo};
    assign quo  = neg_lo ? -lo : lo;
    assign rem  = neg_hi ? -hi : hi;

    assign res_lo = mul_op ? prod[WIDTH-1:0] : quo;
    assign res_hi = mul_op ? prod[2*WIDTH-1:WIDTH] : rem;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIX);

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle datapath plus iterative mul/div unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic             OF,
    output logic             CF,
    output logic             zero,
    output logic             dz
);

    localparam int SHW = $clog2(WIDTH);

    logic             accept, start, is_mul, is_div, is_sgn;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] r, r2;
    logic             of_c, cf_c, dz_c;

    assign in_ready = !md_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (sel == ALU_MULU) || (sel == ALU_MULS);
    assign is_div   = (sel == ALU_DIVU) || (sel == ALU_DIVS);
    assign is_sgn   = (sel == ALU_MULS) || (sel == ALU_DIVS);
    // Divide by zero is answered in one cycle without entering the divider.
    assign start    = accept && is_long_op(sel) && !(is_div && y == '0);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_mul    (is_mul),
        .is_signed (is_sgn),
        .x         (x),
        .y         (y),
        .busy      (md_busy),
        .done      (md_done),
        .res_lo    (md_lo),
        .res_hi    (md_hi)
    );

    assign sh    = y[SHW-1:0];
    assign add_w = {1'b0, x} + {1'b0, y};
    assign sub_w = {1'b0, x} - {1'b0, y};

    always_comb begin
        r    = '0;
        r2   = '0;
        of_c = 1'b0;
        cf_c = 1'b0;
        dz_c = 1'b0;
        case (sel)
            ALU_SLL:  r = x << sh;
            ALU_SRA:  r = $signed(x) >>> sh;
            ALU_SRL:  r = x >> sh;
            ALU_ADD: begin
                r    = add_w[WIDTH-1:0];
                cf_c = add_w[WIDTH];
                of_c = (x[WIDTH-1] == y[WIDTH-1]) &&
                       (add_w[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_SUB: begin
                r    = sub_w[WIDTH-1:0];
                cf_c = sub_w[WIDTH];
                of_c = (x[WIDTH-1] != y[WIDTH-1]) &&
                       (sub_w[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_AND:  r = x & y;
            ALU_OR:   r = x | y;
            ALU_XOR:  r = x ^ y;
            ALU_NOR:  r = ~(x | y);
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            ALU_SLTU: r = {{(WIDTH-1){1'b0}}, x < y};
            ALU_DIVU,
            ALU_DIVS: begin
                r    = '1;
                r2   = x;
                dz_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            result2   <= '0;
            OF        <= 1'b0;
            CF        <= 1'b0;
            zero      <= 1'b0;
            dz        <= 1'b0;
        end else if (accept && !start) begin
            out_valid <= 1'b1;
            result    <= r;
            result2   <= r2;
            OF        <= of_c;
            CF        <= cf_c;
            zero      <= (r == '0);
            dz        <= dz_c;
        end else if (md_done) begin
            out_valid <= 1'b1;
            result    <= md_lo;
            result2   <= md_hi;
            OF        <= 1'b0;
            CF        <= 1'b0;
            zero      <= (md_lo == '0);
            dz        <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
